muldiv_unit: RTL and testbench

Iterative, parametrised multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) beside the single-cycle ALU in the execute stage. It takes operands over a valid/ready handshake and computes one result bit per cycle with a shift-add multiplier or a restoring divider. It holds the result until the consumer accepts it, and reports a zero flag in the same way as the ALU. A flush input abandons an in-flight operation so the core can recover from a pipeline redirect.

---
 rtl/muldiv_unit.sv | 152 +++++++++++++++
 tb/tb_muldiv_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider,
// one result bit per cycle, valid/ready on both sides, flush abandons the current op.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [2:0] {
    OP_MUL  = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010, OP_MULHU = 3'b011,
    OP_DIV  = 3'b100, OP_DIVU = 3'b101, OP_REM    = 3'b110, OP_REMU  = 3'b111
  } op_t;

  state_t            state;
  op_t               op_q;
  logic              neg_q;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;   // mul: {product hi, multiplier/product lo}; div: {remainder, quotient}
  logic [XLEN-1:0]   opd;   // multiplicand or divisor

  // Accept-time decode: operand magnitudes, result sign and special cases.
  logic              abs1_en, abs2_en, neg_in, special;
  logic [XLEN-1:0]   opa, opb, special_res;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    abs1_en     = 1'b0;
    abs2_en     = 1'b0;
    neg_in      = 1'b0;
    special     = 1'b0;
    special_res = '0;
    unique case (op_t'(op))
      OP_MULH:   begin abs1_en = 1'b1; abs2_en = 1'b1; neg_in = src1[XLEN-1] ^ src2[XLEN-1]; end
      OP_MULHSU: begin abs1_en = 1'b1; neg_in = src1[XLEN-1]; end
      OP_DIV:    begin abs1_en = 1'b1; abs2_en = 1'b1; neg_in = src1[XLEN-1] ^ src2[XLEN-1]; end
      OP_REM:    begin abs1_en = 1'b1; abs2_en = 1'b1; neg_in = src1[XLEN-1]; end
      default:   ;
    endcase
    if (op[2]) begin
      if (src2 == '0) begin
        special     = 1'b1;
        special_res = op[1] ? src1 : '1;
      end else if (!op[0] && src1 == {1'b1, {(XLEN-1){1'b0}}} && src2 == '1) begin
        special     = 1'b1;
        special_res = op[1] ? '0 : src1;
      end
    end
  end

  assign opa = (abs1_en && src1[XLEN-1]) ? -src1 : src1;
  assign opb = (abs2_en && src2[XLEN-1]) ? -src2 : src2;

  // One iteration of each datapath, plus the sign-corrected final result.
  logic [XLEN:0]     mul_sum, div_shift;
  logic [XLEN-1:0]   div_sub, div_sel, div_fix, mul_sel, final_res;
  logic [2*XLEN-1:0] mul_next, div_next, mul_fix;
  logic              div_ge;

  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opd};
    mul_next  = acc[0] ? {mul_sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_ge    = div_shift >= {1'b0, opd};
    div_sub   = div_shift[XLEN-1:0] - opd;
    div_next  = div_ge ? {div_sub, acc[XLEN-2:0], 1'b1}
                       : {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    // Negate the full product before picking a half so MULH/MULHSU borrow correctly.
    mul_fix   = neg_q ? -mul_next : mul_next;
    mul_sel   = (op_q == OP_MUL) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];
    div_sel   = op_q[1] ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];
    div_fix   = neg_q ? -div_sel : div_sel;
    final_res = op_q[2] ? div_fix : mul_sel;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      cnt       <= '0;
      acc       <= '0;
      opd       <= '0;
      op_q      <= OP_MUL;
      neg_q     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && !flush) begin
            op_q     <= op_t'(op);
            neg_q    <= neg_in;
            opd      <= op[2] ? opb : opa;
            acc      <= {{XLEN{1'b0}}, (op[2] ? opa : opb)};
            cnt      <= '0;
            in_ready <= 1'b0;
            if (special) begin
              result    <= special_res;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (flush) begin
            state    <= IDLE;
            in_ready <= 1'b1;
          end else begin
            acc <= op_q[2] ? div_next : mul_next;
            cnt <= cnt + CW'(1);
            if (cnt == CW'(XLEN - 1)) begin
              result    <= final_res;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (flush || out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign zero = (result == '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases plus randomized ops
// against an arithmetic reference model, with back-pressure, flush and reset checks.
module tb_muldiv_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2:0]      op = 3'b000;
  logic [XLEN-1:0] src1 = '0;
  logic [XLEN-1:0] src2 = '0;
  logic            flush = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] result;
  logic            zero;

  int checks = 0;
  int failures = 0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .src1(src1), .src2(src2), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // RV32M semantics straight from the ISA rules, using 64-bit integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int     sa, sb;
    sa = a;
    sb = b;
    case (o)
      3'b000: p = longint'(sa) * longint'(sb);
      3'b001: p = (longint'(sa) * longint'(sb)) >>> 32;
      3'b010: p = (longint'(sa) * longint'({32'b0, b})) >>> 32;
      3'b011: p = longint'(({32'b0, a} * {32'b0, b}) >> 32);
      3'b100: p = (b == 0) ? -1 : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? longint'(sa) : longint'(sa / sb);
      3'b101: p = (b == 0) ? -1 : longint'(a / b);
      3'b110: p = (b == 0) ? longint'(sa) : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 0 : longint'(sa % sb);
      default: p = (b == 0) ? longint'(a) : longint'(a % b);
    endcase
    return p[31:0];
  endfunction

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    return o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Called at a negedge with the unit idle; returns at a negedge with the unit idle again.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] exp;
    int lat;
    exp = ref_model(o, a, b);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; op = o; src1 = a; src2 = b;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("latency op%0d", o), lat, is_special(o, a, b) ? 1 : XLEN + 1);
    check($sformatf("result op%0d %0h %0h", o, a, b), result, exp);
    check("zero", zero, exp == 0);
    check("in_ready_busy", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_result", result, exp);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_drop", out_valid, 0);
    check("in_ready_back", in_ready, 1);
  endtask

  task automatic start_and_wait(input logic [2:0] o, input int cycles);
    in_valid = 1'b1; op = o; src1 = 32'h1234_5678; src2 = 32'h0000_0F0F;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 1; i < cycles; i++) @(negedge clk);
  endtask

  task automatic watch_no_valid(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      seen |= out_valid;
    end
    check(tag, seen, 0);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 1);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 0);
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(3'b101, 32'd100, 32'd7, 0);
    run_op(3'b111, 32'd100, 32'd7, 0);
    run_op(3'b110, 32'd6, 32'd3, 0);
    run_op(3'b101, 32'd5, 32'd0, 0);
    run_op(3'b110, 32'd5, 32'd0, 0);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0);

    // Back-pressure, then an immediate back-to-back accept.
    run_op(3'b001, 32'h1234_5678, 32'h9ABC_DEF0, 10);
    run_op(3'b100, 32'h8765_4321, 32'h0000_0013, 0);

    // Flush in IDLE blocks the accept.
    in_valid = 1'b1; flush = 1'b1; op = 3'b000; src1 = 32'd3; src2 = 32'd4;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("idle_flush_no_accept", in_ready, 1);
    watch_no_valid("idle_flush_no_valid", 3);

    // Flush in RUN cycle 5.
    start_and_wait(3'b011, 5);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_run_in_ready", in_ready, 1);
    check("flush_run_out_valid", out_valid, 0);
    watch_no_valid("flush_run_no_result", 40);

    // Flush together with out_ready in DONE: flush wins, unit returns to IDLE.
    in_valid = 1'b1; op = 3'b101; src1 = 32'd9; src2 = 32'd0;
    @(negedge clk);
    in_valid = 1'b0;
    check("flush_done_valid", out_valid, 1);
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    check("flush_done_in_ready", in_ready, 1);
    check("flush_done_out_valid", out_valid, 0);

    // Synchronous reset mid-RUN.
    start_and_wait(3'b000, 10);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result", result, 0);
    check("midrst_zero", zero, 1);
    watch_no_valid("midrst_no_result", 40);

    // Randomized ops with edge-biased operands and occasional back-pressure.
    for (int n = 0; n < 150; n++) begin
      ro = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'($urandom_range(0, 15));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0:       rb = 32'h0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
